// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: round-robin sharing of one ALU between NREQ requesters, one transaction in flight
module alu_req_scheduler #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int C_W      = 4,
    parameter int LAT_NORM = 1,
    parameter int LAT_MUL  = 2,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NREQ-1:0]       REQ_VALID,
    output logic [NREQ-1:0]       REQ_READY,
    input  logic [NREQ*WIDTH-1:0] REQ_OPA,
    input  logic [NREQ*WIDTH-1:0] REQ_OPB,
    input  logic [NREQ*C_W-1:0]   REQ_CMD,
    input  logic [NREQ-1:0]       REQ_MODE,
    input  logic [NREQ-1:0]       REQ_CIN,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [IDW-1:0]        RSP_ID,
    output logic [WIDTH:0]        RSP_RES,
    output logic [5:0]            RSP_FLAGS,
    output logic [WIDTH-1:0]      ALU_OPA,
    output logic [WIDTH-1:0]      ALU_OPB,
    output logic [C_W-1:0]        ALU_CMD,
    output logic [1:0]            ALU_INP_VALID,
    output logic                  ALU_CE,
    output logic                  ALU_MODE,
    output logic                  ALU_CIN,
    input  logic [WIDTH:0]        ALU_RES,
    input  logic                  ALU_ERR,
    input  logic                  ALU_OFLOW,
    input  logic                  ALU_COUT,
    input  logic                  ALU_G,
    input  logic                  ALU_L,
    input  logic                  ALU_E,
    output logic                  BUSY
);
    localparam int LAT_MAX = LAT_MUL > LAT_NORM ? LAT_MUL : LAT_NORM;
    localparam int LW      = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  scan_idx;
    logic            grant_any;
    logic [LW-1:0]   lat_cnt;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (REQ_VALID[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx;
            end
        end
    end

    // Gated by RST_N so no accept can be signalled while the block is held in reset
    assign REQ_READY = (RST_N && state == IDLE && grant_any) ? NREQ'(1) << grant_id : '0;
    assign BUSY      = state != IDLE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            lat_cnt       <= '0;
            RSP_VALID     <= 1'b0;
            RSP_ID        <= '0;
            RSP_RES       <= '0;
            RSP_FLAGS     <= '0;
            ALU_OPA       <= '0;
            ALU_OPB       <= '0;
            ALU_CMD       <= '0;
            ALU_INP_VALID <= 2'b00;
            ALU_CE        <= 1'b0;
            ALU_MODE      <= 1'b0;
            ALU_CIN       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant_any) begin
                    state         <= ISSUE;
                    RSP_ID        <= grant_id;
                    rr_ptr        <= grant_id == IDW'(NREQ - 1) ? '0 : grant_id + 1'b1;
                    ALU_OPA       <= REQ_OPA[grant_id*WIDTH +: WIDTH];
                    ALU_OPB       <= REQ_OPB[grant_id*WIDTH +: WIDTH];
                    ALU_CMD       <= REQ_CMD[grant_id*C_W +: C_W];
                    ALU_MODE      <= REQ_MODE[grant_id];
                    ALU_CIN       <= REQ_CIN[grant_id];
                    ALU_INP_VALID <= 2'b11;
                    ALU_CE        <= 1'b1;
                end
                ISSUE: begin
                    state   <= WAIT;
                    ALU_CE  <= 1'b0;
                    lat_cnt <= (ALU_MODE && (ALU_CMD == C_W'(9) || ALU_CMD == C_W'(10)))
                               ? LW'(LAT_MUL) : LW'(LAT_NORM);
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - LW'(1);
                    if (lat_cnt == LW'(1)) begin
                        state     <= RESP;
                        RSP_VALID <= 1'b1;
                        RSP_RES   <= ALU_RES;
                        RSP_FLAGS <= {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E};
                    end
                end
                RESP: if (RSP_READY) begin
                    state     <= IDLE;
                    RSP_VALID <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb_alu_req_scheduler: scoreboard bench with a behavioural ALU (latency 1, multiply latency 2)
module tb_alu_req_scheduler;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  REQ_VALID = '0;
    logic [3:0]  REQ_READY;
    logic [31:0] REQ_OPA = '0, REQ_OPB = '0;
    logic [15:0] REQ_CMD = '0;
    logic [3:0]  REQ_MODE = '0, REQ_CIN = '0;
    logic        RSP_VALID, RSP_READY = 1'b1;
    logic [1:0]  RSP_ID;
    logic [8:0]  RSP_RES;
    logic [5:0]  RSP_FLAGS;
    logic [7:0]  ALU_OPA, ALU_OPB;
    logic [3:0]  ALU_CMD;
    logic [1:0]  ALU_INP_VALID;
    logic        ALU_CE, ALU_MODE, ALU_CIN;
    logic [8:0]  ALU_RES;
    logic        ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E;
    logic        BUSY;

    alu_req_scheduler dut (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD), .REQ_MODE(REQ_MODE),
        .REQ_CIN(REQ_CIN), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS), .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB),
        .ALU_CMD(ALU_CMD), .ALU_INP_VALID(ALU_INP_VALID), .ALU_CE(ALU_CE),
        .ALU_MODE(ALU_MODE), .ALU_CIN(ALU_CIN), .ALU_RES(ALU_RES), .ALU_ERR(ALU_ERR),
        .ALU_OFLOW(ALU_OFLOW), .ALU_COUT(ALU_COUT), .ALU_G(ALU_G), .ALU_L(ALU_L),
        .ALU_E(ALU_E), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         id;
        logic [8:0] res;
        logic [5:0] flags;
        int         lat;
        int         gcyc;
    } exp_t;

    exp_t sb[$];
    exp_t e, mon_e;
    exp_t bad_e = '{id: -1, res: 9'h1FF, flags: 6'h3F, lat: 0, gcyc: 0};
    int   total = 0, bad = 0, cyc = 0, ce_cnt = 0;
    logic [1:0]  ce_iv = 2'b00;
    logic [14:0] alu_out, alu_pend, mon_v;
    logic        alu_cnt;

    function automatic logic [14:0] alu_calc(input logic [7:0] a, b, input logic [3:0] c, input logic m);
        logic       err;
        logic [8:0] r;
        err = m ? (c > 4'd10) : (c > 4'd13);
        if (err) r = 9'h000;
        else if (m && c == 4'd0) r = {1'b0, a} + {1'b0, b};
        else if (m && (c == 4'd9 || c == 4'd10)) r = {1'b0, a} * {1'b0, b};
        else r = {1'b0, a ^ b};
        return {err, 1'b0, r[8], a > b, a < b, a == b, r};
    endfunction

    // Behavioural ALU: multiply shows a junk value for one cycle before the product
    assign {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E, ALU_RES} = alu_out;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alu_out <= '0; alu_pend <= '0; alu_cnt <= 1'b0;
        end else if (ALU_CE) begin
            if (ALU_MODE && (ALU_CMD == 4'd9 || ALU_CMD == 4'd10)) begin
                alu_out  <= {6'h3F, 9'h155};
                alu_pend <= alu_calc(ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE);
                alu_cnt  <= 1'b1;
            end else alu_out <= alu_calc(ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE);
        end else if (alu_cnt) begin
            alu_out <= alu_pend;
            alu_cnt <= 1'b0;
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard push on every accepted request
    always @(negedge CLK) begin
        if (ALU_CE) begin
            ce_cnt <= ce_cnt + 1;
            ce_iv  <= ALU_INP_VALID;
        end
        if (RST_N && (REQ_READY & REQ_VALID) != 4'b0)
            for (int i = 0; i < 4; i++)
                if (REQ_READY[i]) begin
                    mon_v = alu_calc(REQ_OPA[i*8 +: 8], REQ_OPB[i*8 +: 8], REQ_CMD[i*4 +: 4], REQ_MODE[i]);
                    mon_e.id    = i;
                    mon_e.res   = mon_v[8:0];
                    mon_e.flags = mon_v[14:9];
                    mon_e.lat   = (REQ_MODE[i] && (REQ_CMD[i*4 +: 4] == 4'd9 || REQ_CMD[i*4 +: 4] == 4'd10)) ? 2 : 1;
                    mon_e.gcyc  = cyc;
                    sb.push_back(mon_e);
                end
    end

    task automatic set_req(input int i, input logic [7:0] a, b, input logic [3:0] c, input logic m);
        REQ_OPA[i*8 +: 8] = a;
        REQ_OPB[i*8 +: 8] = b;
        REQ_CMD[i*4 +: 4] = c;
        REQ_MODE[i]       = m;
        REQ_CIN[i]        = 1'b0;
    endtask

    task automatic wait_grant(output bit ok, output int id);
        ok = 0; id = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if ((REQ_READY & REQ_VALID) != 4'b0) begin
                ok = 1;
                for (int i = 0; i < 4; i++) if (REQ_READY[i]) id = i;
                break;
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (RSP_VALID) begin ok = 1; break; end
        end
    endtask

    function automatic exp_t pop_exp();
        return sb.size() != 0 ? sb.pop_front() : bad_e;
    endfunction

    task automatic test_reset();
        RST_N = 1'b0; REQ_VALID = 4'b1111;
        repeat (2) @(negedge CLK);
        total++;
        if (REQ_READY !== 4'b0 || RSP_VALID !== 1'b0 || BUSY !== 1'b0 || ALU_CE !== 1'b0) begin
            bad++; $display("FAIL reset_ctl: ready=%b rsp_valid=%b busy=%b ce=%b, want 0000 0 0 0", REQ_READY, RSP_VALID, BUSY, ALU_CE);
        end
        total++;
        if (RSP_ID !== 2'd0 || RSP_RES !== 9'd0 || RSP_FLAGS !== 6'd0) begin
            bad++; $display("FAIL reset_rsp: id=%0d res=%h flags=%b, want 0 000 000000", RSP_ID, RSP_RES, RSP_FLAGS);
        end
        total++;
        if (ALU_INP_VALID !== 2'b00 || ALU_OPA !== 8'd0 || ALU_OPB !== 8'd0 || ALU_CMD !== 4'd0 || ALU_MODE !== 1'b0 || ALU_CIN !== 1'b0) begin
            bad++; $display("FAIL reset_alu: iv=%b opa=%h opb=%h cmd=%h mode=%b cin=%b, want all 0", ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN);
        end
        REQ_VALID = 4'b0;
        @(posedge CLK); #1 RST_N = 1'b1;
    endtask

    task automatic test_single();
        bit ok; int id, g, c0;
        @(posedge CLK); #1;
        c0 = ce_cnt;
        set_req(2, 8'h0F, 8'h01, 4'd0, 1'b1);
        REQ_VALID = 4'b0100;
        wait_grant(ok, id); g = cyc;
        total++;
        if (!ok || id != 2) begin bad++; $display("FAIL single_grant: ok=%0d id=%0d, want 1 2", ok, id); end
        @(posedge CLK); #1 REQ_VALID = 4'b0;
        wait_valid(ok);
        total++;
        if (!ok || cyc != g + 3) begin bad++; $display("FAIL single_latency: ok=%0d delay=%0d, want 1 3", ok, cyc - g); end
        total++;
        if (RSP_ID !== 2'd2 || RSP_RES !== 9'h010) begin bad++; $display("FAIL single_rsp: id=%0d res=%h, want 2 010", RSP_ID, RSP_RES); end
        e = pop_exp();
        total++;
        if (RSP_ID !== 2'(e.id) || RSP_RES !== e.res || RSP_FLAGS !== e.flags) begin
            bad++; $display("FAIL single_sb: id=%0d res=%h flags=%b, want %0d %h %b", RSP_ID, RSP_RES, RSP_FLAGS, e.id, e.res, e.flags);
        end
        total++;
        if (ce_cnt - c0 != 1 || ce_iv !== 2'b11) begin bad++; $display("FAIL single_ce: pulses=%0d iv=%b, want 1 11", ce_cnt - c0, ce_iv); end
    endtask

    task automatic test_mul();
        bit ok; int id, g;
        @(posedge CLK); #1;
        set_req(1, 8'd3, 8'd4, 4'd9, 1'b1);
        REQ_VALID = 4'b0010;
        wait_grant(ok, id); g = cyc;
        @(posedge CLK); #1 REQ_VALID = 4'b0;
        wait_valid(ok);
        total++;
        if (!ok || id != 1 || cyc != g + 4) begin bad++; $display("FAIL mul_latency: ok=%0d id=%0d delay=%0d, want 1 1 4", ok, id, cyc - g); end
        e = pop_exp();
        total++;
        if (RSP_RES !== 9'h00C || RSP_RES !== e.res || RSP_FLAGS !== e.flags || RSP_ID !== 2'd1) begin
            bad++; $display("FAIL mul_rsp: id=%0d res=%h flags=%b, want 1 00c %b", RSP_ID, RSP_RES, RSP_FLAGS, e.flags);
        end
    endtask

    task automatic test_illegal();
        bit ok; int id, g;
        @(posedge CLK); #1;
        set_req(2, 8'h05, 8'h06, 4'd12, 1'b1);
        REQ_VALID = 4'b0100;
        wait_grant(ok, id); g = cyc;
        @(posedge CLK); #1 REQ_VALID = 4'b0;
        wait_valid(ok);
        e = pop_exp();
        total++;
        if (!ok || cyc != g + 3 || RSP_FLAGS[5] !== 1'b1 || RSP_FLAGS !== e.flags || RSP_RES !== e.res) begin
            bad++; $display("FAIL illegal_rsp: ok=%0d delay=%0d flags=%b res=%h, want 1 3 %b %h", ok, cyc - g, RSP_FLAGS, RSP_RES, e.flags, e.res);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int id;
        logic [1:0] sid; logic [8:0] sres; logic [5:0] sfl;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        set_req(3, 8'h80, 8'h90, 4'd0, 1'b1);
        REQ_VALID = 4'b1000;
        wait_grant(ok, id);
        @(posedge CLK); #1;
        set_req(0, 8'h22, 8'h22, 4'd0, 1'b0);
        REQ_VALID = 4'b0001;
        wait_valid(ok);
        sid = RSP_ID; sres = RSP_RES; sfl = RSP_FLAGS;
        e = pop_exp();
        total++;
        if (!ok || sid !== 2'd3 || sres !== e.res || sfl !== e.flags) begin
            bad++; $display("FAIL bp_rsp: ok=%0d id=%0d res=%h flags=%b, want 1 3 %h %b", ok, sid, sres, sfl, e.res, e.flags);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            total++;
            if (RSP_VALID !== 1'b1 || RSP_ID !== sid || RSP_RES !== sres || RSP_FLAGS !== sfl || REQ_READY !== 4'b0 || ALU_CE !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d]: valid=%b id=%0d res=%h ready=%b ce=%b, want 1 %0d %h 0000 0", k, RSP_VALID, RSP_ID, RSP_RES, REQ_READY, ALU_CE, sid, sres);
            end
        end
        @(posedge CLK); #1 RSP_READY = 1'b1;
        @(negedge CLK);
        total++;
        if (REQ_READY !== 4'b0000 || RSP_VALID !== 1'b1) begin bad++; $display("FAIL bp_release: ready=%b valid=%b, want 0000 1", REQ_READY, RSP_VALID); end
        @(negedge CLK);
        total++;
        if (REQ_READY !== 4'b0001) begin bad++; $display("FAIL bp_next_grant: ready=%b, want 0001", REQ_READY); end
        @(posedge CLK); #1 REQ_VALID = 4'b0;
        wait_valid(ok);
        e = pop_exp();
        total++;
        if (!ok || RSP_ID !== 2'd0 || RSP_RES !== e.res || RSP_FLAGS !== e.flags) begin
            bad++; $display("FAIL bp_second: ok=%0d id=%0d res=%h flags=%b, want 1 0 %h %b", ok, RSP_ID, RSP_RES, RSP_FLAGS, e.res, e.flags);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int id, g, prev;
        @(posedge CLK); #1;
        set_req(1, 8'h41, 8'h14, 4'd3, 1'b0);
        REQ_VALID = 4'b0010;
        prev = 0;
        for (int n = 0; n < 3; n++) begin
            wait_grant(ok, id); g = cyc;
            total++;
            if (!ok || id != 1 || (n > 0 && g - prev != 4)) begin
                bad++; $display("FAIL b2b_grant[%0d]: ok=%0d id=%0d gap=%0d, want 1 1 4", n, ok, id, g - prev);
            end
            prev = g;
            if (n == 2) begin @(posedge CLK); #1 REQ_VALID = 4'b0; end
            wait_valid(ok);
            e = pop_exp();
            total++;
            if (!ok || RSP_ID !== 2'd1 || RSP_RES !== e.res || RSP_FLAGS !== e.flags) begin
                bad++; $display("FAIL b2b_rsp[%0d]: ok=%0d id=%0d res=%h, want 1 1 %h", n, ok, RSP_ID, RSP_RES, e.res);
            end
        end
    endtask

    task automatic test_fairness();
        bit ok; int id, g, prev;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 8'(i * 16 + 5), 8'(i + 1), 4'd0, 1'b1);
        REQ_VALID = 4'b1111;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        prev = 0;
        for (int n = 0; n < 8; n++) begin
            wait_grant(ok, id); g = cyc;
            total++;
            if (!ok || id != n % 4 || (n > 0 && g - prev != 4)) begin
                bad++; $display("FAIL fair_grant[%0d]: ok=%0d id=%0d gap=%0d, want 1 %0d 4", n, ok, id, g - prev, n % 4);
            end
            prev = g;
            if (n == 7) begin @(posedge CLK); #1 REQ_VALID = 4'b0; end
            wait_valid(ok);
            e = pop_exp();
            total++;
            if (!ok || RSP_ID !== 2'(n % 4) || RSP_RES !== e.res || RSP_FLAGS !== e.flags) begin
                bad++; $display("FAIL fair_rsp[%0d]: ok=%0d id=%0d res=%h, want 1 %0d %h", n, ok, RSP_ID, RSP_RES, n % 4, e.res);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int id;
        @(posedge CLK); #1;
        set_req(2, 8'd7, 8'd9, 4'd10, 1'b1);
        REQ_VALID = 4'b0100;
        wait_grant(ok, id);
        @(posedge CLK); #1;
        REQ_VALID = 4'b1111;
        @(posedge CLK); #1;
        total++;
        if (BUSY !== 1'b1 || ALU_CE !== 1'b0 || RSP_VALID !== 1'b0) begin
            bad++; $display("FAIL rst_mid_wait: busy=%b ce=%b valid=%b, want 1 0 0", BUSY, ALU_CE, RSP_VALID);
        end
        #1 RST_N = 1'b0;
        #1;
        total++;
        if (BUSY !== 1'b0 || ALU_INP_VALID !== 2'b00 || ALU_OPA !== 8'd0 || ALU_CMD !== 4'd0 || ALU_MODE !== 1'b0 || RSP_ID !== 2'd0 || REQ_READY !== 4'b0) begin
            bad++; $display("FAIL rst_mid_async: busy=%b iv=%b opa=%h cmd=%h mode=%b id=%0d ready=%b, want 0 00 00 0 0 0 0000", BUSY, ALU_INP_VALID, ALU_OPA, ALU_CMD, ALU_MODE, RSP_ID, REQ_READY);
        end
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            total++;
            if (RSP_VALID !== 1'b0 || RSP_RES !== 9'd0) begin bad++; $display("FAIL rst_mid_rsp[%0d]: valid=%b res=%h, want 0 000", k, RSP_VALID, RSP_RES); end
        end
        @(posedge CLK); #1 RST_N = 1'b1;
        wait_grant(ok, id);
        total++;
        if (!ok || id != 0) begin bad++; $display("FAIL rst_mid_first: ok=%0d id=%0d, want 1 0", ok, id); end
        @(posedge CLK); #1 REQ_VALID = 4'b0;
        wait_valid(ok);
        e = pop_exp();
        total++;
        if (!ok || RSP_ID !== 2'd0 || RSP_RES !== e.res || RSP_FLAGS !== e.flags) begin
            bad++; $display("FAIL rst_mid_after: ok=%0d id=%0d res=%h, want 1 0 %h", ok, RSP_ID, RSP_RES, e.res);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_fairness();
        test_reset_mid();
        repeat (3) @(negedge CLK);
        total++;
        if (sb.size() != 0 || RSP_VALID !== 1'b0) begin bad++; $display("FAIL drain: pending=%0d valid=%b, want 0 0", sb.size(), RSP_VALID); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_req_scheduler.md
# alu_req_scheduler

Shares one ALU instance between `NREQ` independent requesters. Round-robin arbitration picks one pending request, issues it to the ALU as a single complete-operand transaction (`INP_VALID=2'b11`, `CE` pulsed for one cycle) and waits the command-dependent ALU latency. It then captures `RES` and the flag outputs and returns them to the winning requester over a valid/ready response channel. The block sits between requester logic and the ALU; it guarantees the ALU never receives a split-operand (`01`/`10`) sequence.

## Interface
- `NREQ`, 4 — number of requesters (2..8)
- `WIDTH`, 8 — operand width; matches the ALU `` `WIDTH ``
- `C_W`, 4 — command width; matches the ALU `` `C_W ``
- `LAT_NORM`, 1 — ALU latency in cycles for non-multiply commands
- `LAT_MUL`, 2 — ALU latency for `MODE=1`, `CMD` 9 or 10 (multiply)
- `IDW` is derived locally as `$clog2(NREQ)`
- `CLK` in 1 — single clock, rising edge
- `RST_N` in 1 — asynchronous, active-low reset
- `REQ_VALID` in NREQ — per-requester request valid
- `REQ_READY` out NREQ — per-requester accept, one-hot or zero
- `REQ_OPA`, `REQ_OPB` in NREQ*WIDTH — packed operands; requester i uses slice [i*WIDTH +: WIDTH]
- `REQ_CMD` in NREQ*C_W — packed commands
- `REQ_MODE`, `REQ_CIN` in NREQ — per-requester mode and carry-in
- `RSP_VALID` out 1 — response valid
- `RSP_READY` in 1 — response accept
- `RSP_ID` out IDW — index of the requester that owns the response
- `RSP_RES` out WIDTH+1 — captured ALU `RES`
- `RSP_FLAGS` out 6 — captured {ERR, OFLOW, COUT, G, L, E}
- `ALU_OPA`, `ALU_OPB` out WIDTH; `ALU_CMD` out C_W; `ALU_INP_VALID` out 2; `ALU_CE`, `ALU_MODE`, `ALU_CIN` out 1 — drive the ALU
- `ALU_RES` in WIDTH+1; `ALU_ERR`, `ALU_OFLOW`, `ALU_COUT`, `ALU_G`, `ALU_L`, `ALU_E` in 1 — ALU outputs
- `BUSY` out 1 — high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any `REQ_VALID` is set, grant the first set bit at or after `rr_ptr`, searching upward with wrap. Assert that `REQ_READY` bit combinationally in this cycle. On the clock edge, latch the winner's OPA/OPB/CMD/MODE/CIN and id, set `rr_ptr = winner+1` (mod NREQ), and go to ISSUE. `REQ_READY` is zero in every other state.
- **ISSUE (1 cycle):** `ALU_CE=1`, `ALU_INP_VALID=2'b11`, ALU operand and command outputs come from the latched request. Load `lat_cnt` with `LAT_MUL` if MODE=1 and CMD is 9 or 10, otherwise `LAT_NORM`. Go to WAIT.
- **WAIT:** decrement `lat_cnt` each cycle. In the cycle where `lat_cnt==1`, sample `ALU_RES` and the six flags into the response registers and go to RESP.
- **RESP:** `RSP_VALID=1`. `RSP_ID`, `RSP_RES` and `RSP_FLAGS` stay stable until `RSP_READY`. On `RSP_VALID && RSP_READY`, go to IDLE.
- Outside ISSUE, `ALU_CE=0` so the ALU holds its outputs. `ALU_OPA`, `ALU_OPB`, `ALU_CMD`, `ALU_MODE`, `ALU_CIN` and `ALU_INP_VALID` hold their last driven values.
- Illegal commands (MODE=1 with CMD>10, MODE=0 with CMD>13) are forwarded unchanged. The ALU's ERR is returned in `RSP_FLAGS[5]` and the scheduler takes no action on it.
- Only one transaction is ever outstanding. Requests that arrive while BUSY wait; `REQ_VALID` must stay high until `REQ_READY`.

## Timing
- Reset (`RST_N` low, asynchronous): state=IDLE, `rr_ptr=0`, `lat_cnt=0`, `REQ_READY=0`, `RSP_VALID=0`, `RSP_ID=0`, `RSP_RES=0`, `RSP_FLAGS=0`, `ALU_CE=0`, `ALU_INP_VALID=2'b00`, all other ALU outputs 0, `BUSY=0`.
- Reset asserted mid-transaction aborts it. The in-flight response is lost and no `RSP_VALID` is produced.
- Grant at cycle G. ISSUE occurs at G+1. Capture occurs at G+1+L, where L is the latency. `RSP_VALID` rises at G+2+L.
- Minimum turnaround is G+3+L. This applies when `RSP_READY` is high on the first RESP cycle: the next grant can happen in cycle G+3+L.
- Simultaneous requests from all requesters are served in strict rotation starting at `rr_ptr`. A requester that holds `REQ_VALID` continuously is served at most once per NREQ grants while others are pending.
- A sole requester is re-granted back-to-back, because the rotation search wraps to it.

## Test plan
- Single request: requester 2 sends ADD with OPA=8'h0F, OPB=8'h01, MODE=1 -> exactly one `ALU_CE` pulse with `ALU_INP_VALID=11`; `RSP_VALID` appears 3 cycles after the grant (L=1) with `RSP_ID=2` and `RSP_RES=9'h010`.
- Multiply latency: MODE=1, CMD=9, OPA=3, OPB=4 -> `RSP_VALID` appears at G+4, and `RSP_RES` equals the ALU's multiply result (`RES` sampled in the capture cycle).
- Fairness: all 4 `REQ_VALID` high continuously from reset -> grant order 0,1,2,3,0,1…; no requester is granted twice before the others have each been granted once.
- Backpressure: hold `RSP_READY=0` for 10 cycles -> `RSP_*` stays stable, `REQ_READY` stays 0, `ALU_CE` stays 0; one cycle after `RSP_READY` goes high, the next grant occurs.
- Reset mid-WAIT: drop `RST_N` during WAIT -> all outputs take their reset values immediately, with no `RSP_VALID`; after release, the first grant goes to requester 0.
- Illegal command: MODE=1, CMD=12 -> the request is issued normally and the response carries `RSP_FLAGS[5]=1`.
